// File: rtl/fifo_chk_pkg.sv
// Shared types and default widths for the FIFO read-side sequence checker.
package fifo_chk_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 16;

  typedef enum logic {
    ST_HUNT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;
endpackage

// File: rtl/fifo_seq_checker_rd_tick_gen.sv
// Pop-rate divider with a one-deep pending request; a tick in the current cycle
// is visible on pending immediately so RD_DIV=1 pops every cycle from reset.
module rd_tick_gen #(
  parameter int RD_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic pop,
  output logic pending
);
  localparam int DW = 16;
  localparam logic [DW-1:0] TC  = DW'(RD_DIV - 1);
  localparam logic [DW-1:0] ONE = DW'(1);

  logic [DW-1:0] div;
  logic          pend_q;
  logic          tick;

  assign tick    = en & (div == TC);
  assign pending = pend_q | tick;

  // Extra ticks while a request waits are absorbed: pending is a single bit.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      div    <= '0;
      pend_q <= 1'b0;
    end else if (en) begin
      div    <= tick ? '0 : div + ONE;
      pend_q <= pending & ~pop;
    end
  end
endmodule

// File: rtl/fifo_seq_checker.sv
// Read-domain consumer: pops the FIFO at a divided rate, locks to the first word
// and flags any word that is not the previous word plus STEP (mod 2^WIDTH).
module fifo_seq_checker
  import fifo_chk_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP   = 1,
  parameter int RD_DIV = 1,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             Rempty,
  input  logic [WIDTH-1:0] Rdata,
  output logic             Rinc,
  output logic [WIDTH-1:0] data_out,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             locked,
  output logic             err_flag,
  output logic             err_pulse
);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nx;
  logic             pending;
  logic             pop;
  logic             load;
  logic             mismatch;
  logic [WIDTH-1:0] expected;

  // rst and clr both veto the pop so no word is lost while state is being wiped.
  assign pop  = en & pending & ~Rempty & ~rst & ~clr;
  assign Rinc = pop;

  rd_tick_gen #(.RD_DIV(RD_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clr     (clr),
    .pop     (pop),
    .pending (pending)
  );

  always_ff @(posedge clk) begin
    if (rst || clr) state <= ST_HUNT;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (pop && state == ST_HUNT) state_nx = ST_TRACK;
  end

  always_comb begin
    load     = pop;
    mismatch = pop && (state == ST_TRACK) && (Rdata != expected);
  end

  // expected always reloads from the popped word, so a gap costs one error only.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      expected  <= '0;
      word_cnt  <= '0;
      err_cnt   <= '0;
      locked    <= 1'b0;
      err_flag  <= 1'b0;
      err_pulse <= 1'b0;
    end else if (clr) begin
      expected  <= '0;
      word_cnt  <= '0;
      err_cnt   <= '0;
      locked    <= 1'b0;
      err_flag  <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= mismatch;
      if (load) begin
        data_out <= Rdata;
        expected <= Rdata + STEP_W;
        locked   <= 1'b1;
        if (word_cnt != CNT_MAX) word_cnt <= word_cnt + CNT_ONE;
      end
      if (mismatch) begin
        err_flag <= 1'b1;
        if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_ONE;
      end
    end
  end
endmodule

// File: tb/tb_fifo_seq_checker.sv
// Directed bench: a FWFT FIFO model feeds an RD_DIV=1 checker; a second
// instance with RD_DIV=4 is driven directly to check rate and empty stalls.
module tb_fifo_seq_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RD_DIV=1 instance fed from a FWFT model
  logic        rst1, en1, clr1, empty1, rinc1, lk1, ef1, ep1;
  logic [15:0] rdata1, dout1, wc1, ec1;
  logic [15:0] mem [0:63];
  int          wp = 0, rp = 0, pops1 = 0, pulses1 = 0;
  logic [15:0] pulse_word = 16'h0;

  assign empty1 = (wp == rp);
  assign rdata1 = mem[rp[5:0]];

  always @(posedge clk) if (rinc1) begin
    rp    <= rp + 1;
    pops1 <= pops1 + 1;
  end

  always @(negedge clk) if (ep1) begin
    pulses1    <= pulses1 + 1;
    pulse_word <= dout1;
  end

  fifo_seq_checker #(.WIDTH(16), .STEP(1), .RD_DIV(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .clr(clr1), .Rempty(empty1), .Rdata(rdata1),
    .Rinc(rinc1), .data_out(dout1), .word_cnt(wc1), .err_cnt(ec1),
    .locked(lk1), .err_flag(ef1), .err_pulse(ep1)
  );

  // RD_DIV=4 instance driven directly
  logic        rst4, en4, clr4, empty4, rinc4, lk4, ef4, ep4;
  logic [15:0] rdata4, dout4, wc4, ec4;

  fifo_seq_checker #(.WIDTH(16), .STEP(1), .RD_DIV(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst4), .en(en4), .clr(clr4), .Rempty(empty4), .Rdata(rdata4),
    .Rinc(rinc4), .data_out(dout4), .word_cnt(wc4), .err_cnt(ec4),
    .locked(lk4), .err_flag(ef4), .err_pulse(ep4)
  );

  task automatic push(input logic [15:0] v);
    mem[wp[5:0]] = v;
    wp = wp + 1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset1(input string tag);
    chk({tag, "_dout"},  32'(dout1), 32'h0);
    chk({tag, "_wcnt"},  32'(wc1),   32'h0);
    chk({tag, "_ecnt"},  32'(ec1),   32'h0);
    chk({tag, "_lock"},  32'(lk1),   32'h0);
    chk({tag, "_eflag"}, 32'(ef1),   32'h0);
    chk({tag, "_epuls"}, 32'(ep1),   32'h0);
  endtask

  initial begin
    int base, p;
    logic exp_r;
    rst1 = 1'b1; en1 = 1'b1; clr1 = 1'b0;
    rst4 = 1'b1; en4 = 1'b1; clr4 = 1'b0; empty4 = 1'b1; rdata4 = 16'h0;
    cyc(2);
    chk_reset1("rst");
    chk("rst_rinc", 32'(rinc1), 32'h0);

    // In-order stream 0..9; Rinc must stay low while rst is still high
    for (int i = 0; i < 10; i++) push(16'(i));
    #1 chk("rinc_in_rst", 32'(rinc1), 32'h0);
    rst1 = 1'b0;
    #1 chk("rinc_first", 32'(rinc1), 32'h1);
    base = pops1;
    cyc(12);
    chk("seq_pops", 32'(pops1 - base), 32'd10);
    chk("seq_dout", 32'(dout1), 32'h9);
    chk("seq_wcnt", 32'(wc1),   32'd10);
    chk("seq_ecnt", 32'(ec1),   32'd0);
    chk("seq_lock", 32'(lk1),   32'h1);

    // Wrap-around
    clr1 = 1'b1; cyc(1); clr1 = 1'b0;
    push(16'hFFFE); push(16'hFFFF); push(16'h0000); push(16'h0001);
    cyc(6);
    chk("wrap_ecnt", 32'(ec1),  32'd0);
    chk("wrap_dout", 32'(dout1), 32'h1);
    chk("wrap_wcnt", 32'(wc1),  32'd4);

    // Dropped word: 5,6,8,9 -> exactly one error, reported while data_out=8
    clr1 = 1'b1; cyc(1); clr1 = 1'b0;
    p = pulses1;
    push(16'd5); push(16'd6); push(16'd8); push(16'd9);
    cyc(6);
    chk("drop_pulses", 32'(pulses1 - p), 32'd1);
    chk("drop_pword",  32'(pulse_word),  32'd8);
    chk("drop_ecnt",   32'(ec1),         32'd1);
    chk("drop_eflag",  32'(ef1),         32'h1);
    chk("drop_wcnt",   32'(wc1),         32'd4);
    chk("drop_dout",   32'(dout1),       32'd9);

    // clr in the same cycle as a non-empty FIFO
    clr1 = 1'b1;
    push(16'h1234); push(16'h1235);
    base = pops1;
    #1 chk("clr_rinc", 32'(rinc1), 32'h0);
    cyc(1);
    chk("clr_pops",  32'(pops1 - base), 32'd0);
    chk("clr_wcnt",  32'(wc1), 32'd0);
    chk("clr_ecnt",  32'(ec1), 32'd0);
    chk("clr_eflag", 32'(ef1), 32'h0);
    chk("clr_lock",  32'(lk1), 32'h0);
    clr1 = 1'b0;
    cyc(4);
    chk("relock_wcnt", 32'(wc1),   32'd2);
    chk("relock_ecnt", 32'(ec1),   32'd0);
    chk("relock_dout", 32'(dout1), 32'h1235);
    chk("relock_lock", 32'(lk1),   32'h1);

    // Reset mid-stream after 3 pops
    base = pops1;
    for (int i = 0; i < 10; i++) push(16'h0100 + 16'(i));
    cyc(3);
    chk("mid_pops3", 32'(pops1 - base), 32'd3);
    chk("mid_dout3", 32'(dout1), 32'h0102);
    rst1 = 1'b1;
    #1 chk("mid_rinc_rst", 32'(rinc1), 32'h0);
    cyc(1);
    chk_reset1("mid_rst");
    chk("mid_pops_hold", 32'(pops1 - base), 32'd3);
    rst1 = 1'b0;
    cyc(9);
    chk("post_wcnt",  32'(wc1),   32'd7);
    chk("post_ecnt",  32'(ec1),   32'd0);
    chk("post_dout",  32'(dout1), 32'h0109);
    chk("post_eflag", 32'(ef1),   32'h0);
    chk("post_lock",  32'(lk1),   32'h1);

    // RD_DIV=4: every 4th cycle while non-empty, then an empty stall and refill
    empty4 = 1'b0;
    rst4 = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (i == 12) empty4 = 1'b1;
      if (i == 22) empty4 = 1'b0;
      if (i == 23) empty4 = 1'b1;
      #1;
      exp_r = (i < 12) ? ((i % 4) == 3) : (i == 22);
      chk($sformatf("rate_rinc_%0d", i), 32'(rinc4), 32'(exp_r));
      @(negedge clk);
    end
    chk("rate_wcnt", 32'(wc4), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
